// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants, FSM state type and saturating add for the BNN partial-sum back-end
package bnn_pkg;

    localparam int CH_DEF     = 8;
    localparam int PSUM_W_DEF = 7;
    localparam int BIAS_W_DEF = 8;
    localparam int ACC_W_DEF  = 11;
    localparam int DEPTH_DEF  = 8;
    localparam int OUT_CH_DEF = 4;
    localparam int POOL_N_DEF = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Adds two sign-extended operands and clamps the result to a signed w-bit range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] s;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        s  = 33'(a) + 33'(b);
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -hi - 33'sd1;
        if (s > hi)
            return 32'(hi);
        else if (s < lo)
            return 32'(lo);
        else
            return 32'(s);
    endfunction

endpackage

// File: rtl/bnn_sat_acc.sv
// rtl/bnn_sat_acc.sv - one output channel: bias register, saturating accumulator and sign bit
module bnn_sat_acc
    import bnn_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bias_wr,
    input  logic [BIAS_W-1:0] bias_in,
    input  logic              acc_clr,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum_in,
    output logic              bin
);

    logic signed [BIAS_W-1:0] bias;
    logic signed [ACC_W-1:0]  acc;

    always_ff @(posedge clk) begin
        if (rst)
            bias <= '0;
        else if (bias_wr)
            bias <= $signed(bias_in);
    end

    // A load from bias cannot overflow because ACC_W exceeds both operand widths.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (acc_clr && psum_valid)
            acc <= ACC_W'(bias) + ACC_W'($signed(psum_in));
        else if (acc_clr)
            acc <= ACC_W'(bias);
        else if (psum_valid)
            acc <= ACC_W'(sat_add(32'(acc), 32'($signed(psum_in)), ACC_W));
    end

    assign bin = ~acc[ACC_W-1];

endmodule

// File: rtl/bnn_psum_binarizer.sv
// rtl/bnn_psum_binarizer.sv - per-channel accumulate, sign binarise, OR-pool, row buffer and transposed drain
module bnn_psum_binarizer
    import bnn_pkg::*;
#(
    parameter int CH     = CH_DEF,
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int BIAS_W = BIAS_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int OUT_CH = OUT_CH_DEF,
    parameter int POOL_N = POOL_N_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bias_wr,
    input  logic [CH*BIAS_W-1:0]    bias_in,
    input  logic                    acc_clr,
    input  logic                    psum_valid,
    input  logic [CH*PSUM_W-1:0]    psum_in,
    input  logic                    bin_wr,
    input  logic                    pool_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_CH*DEPTH-1:0] out_data,
    output logic                    busy,
    output logic                    err_overflow
);

    localparam int NBEAT  = CH / OUT_CH;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int RC_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PC_W   = $clog2(POOL_N);

    state_t                  state, state_nxt;
    logic [CH-1:0]           bin;
    logic [CH-1:0]           pool_reg;
    logic [PC_W-1:0]         pool_cnt;
    logic [CH-1:0]           rows     [DEPTH];
    logic [CH-1:0]           rows_nxt [DEPTH];
    logic [RC_W-1:0]         row_cnt;
    logic [BEAT_W-1:0]       beat;
    logic [BEAT_W:0]         sel_beat;
    logic [OUT_CH*DEPTH-1:0] beat_data;
    logic                    wr_ok, pool_last, push, fill_done, hs, last_beat;
    logic [CH-1:0]           push_row;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        bnn_sat_acc #(
            .PSUM_W(PSUM_W),
            .BIAS_W(BIAS_W),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk       (clk),
            .rst       (rst),
            .bias_wr   (bias_wr),
            .bias_in   (bias_in[c*BIAS_W +: BIAS_W]),
            .acc_clr   (acc_clr),
            .psum_valid(psum_valid),
            .psum_in   (psum_in[c*PSUM_W +: PSUM_W]),
            .bin       (bin[c])
        );
    end

    assign wr_ok     = bin_wr && (state == FILL);
    assign pool_last = (pool_cnt == PC_W'(POOL_N - 1));
    assign push      = wr_ok && (!pool_en || pool_last);
    assign push_row  = pool_en ? (pool_reg | bin) : bin;
    assign fill_done = push && (row_cnt == RC_W'(DEPTH - 1));
    assign hs        = (state == DRAIN) && out_ready;
    assign last_beat = (beat == BEAT_W'(NBEAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pool_reg <= '0;
            pool_cnt <= '0;
        end else if (wr_ok) begin
            if (pool_en && !pool_last) begin
                pool_reg <= (pool_cnt == '0) ? bin : (pool_reg | bin);
                pool_cnt <= pool_cnt + 1'b1;
            end else begin
                pool_reg <= '0;
                pool_cnt <= '0;
            end
        end
    end

    always_comb begin
        rows_nxt = rows;
        if (push)
            rows_nxt[row_cnt] = push_row;
    end

    // While draining no push can happen, so rows_nxt equals rows and serves both cases.
    always_comb begin
        sel_beat  = (state == FILL) ? '0 : ({1'b0, beat} + 1'b1);
        beat_data = '0;
        for (int ch = 0; ch < CH; ch++)
            for (int r = 0; r < DEPTH; r++)
                if (ch / OUT_CH == int'(sel_beat))
                    beat_data[(ch % OUT_CH) * DEPTH + r] = rows_nxt[r][ch];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++)
                rows[r] <= '0;
            row_cnt      <= '0;
            beat         <= '0;
            out_data     <= '0;
            err_overflow <= 1'b0;
        end else begin
            rows <= rows_nxt;
            if (fill_done)
                row_cnt <= '0;
            else if (push)
                row_cnt <= row_cnt + 1'b1;
            if (fill_done)
                beat <= '0;
            else if (hs && !last_beat)
                beat <= beat + 1'b1;
            if (fill_done || (hs && !last_beat))
                out_data <= beat_data;
            if (bin_wr && (state == DRAIN))
                err_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (fill_done) state_nxt = DRAIN;
            DRAIN:   if (hs && last_beat) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        if (state == DRAIN) begin
            busy      = 1'b1;
            out_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_bnn_psum_binarizer.sv
// tb/tb_bnn_psum_binarizer.sv - directed self-checking bench for bnn_psum_binarizer
module tb_bnn_psum_binarizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        bias_wr;
    logic [63:0] bias_in;
    logic        acc_clr;
    logic        psum_valid;
    logic [55:0] psum_in;
    logic        bin_wr;
    logic        pool_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        err_overflow;

    int tests = 0;
    int fails = 0;
    logic [31:0] held;

    bnn_psum_binarizer dut (
        .clk         (clk),
        .rst         (rst),
        .bias_wr     (bias_wr),
        .bias_in     (bias_in),
        .acc_clr     (acc_clr),
        .psum_valid  (psum_valid),
        .psum_in     (psum_in),
        .bin_wr      (bin_wr),
        .pool_en     (pool_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bias_all(input logic [7:0] v);
        for (int c = 0; c < 8; c++) bias_in[c*8 +: 8] = v;
    endtask

    task automatic set_psum_all(input logic [6:0] v);
        for (int c = 0; c < 8; c++) psum_in[c*7 +: 7] = v;
    endtask

    // Force each channel's sign: bias +1 gives bin 1, bias -1 gives bin 0.
    task automatic load_bins(input logic [7:0] b);
        for (int c = 0; c < 8; c++) bias_in[c*8 +: 8] = b[c] ? 8'h01 : 8'hFF;
        bias_wr = 1'b1;
        tick();
        bias_wr = 1'b0;
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
    endtask

    task automatic write_row(input logic [7:0] b);
        load_bins(b);
        bin_wr = 1'b1;
        tick();
        bin_wr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bias_wr = 0; bias_in = '0; acc_clr = 0; psum_valid = 0;
        psum_in = '0; bin_wr = 0; pool_en = 0; out_ready = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err_overflow}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_acc0", {21'd0, dut.g_ch[0].u_acc.acc}, 32'd0);

        // bias/accumulate
        bias_in[0 +: 8] = 8'hFB;
        bias_in[8 +: 8] = 8'h03;
        bias_wr = 1'b1; tick(); bias_wr = 1'b0;
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        psum_in[0 +: 7] = 7'h04;
        psum_in[7 +: 7] = 7'h7C;
        psum_valid = 1'b1; tick();
        chk("acc0_m1", {21'd0, dut.g_ch[0].u_acc.acc}, 32'h7FF);
        chk("acc1_m1", {21'd0, dut.g_ch[1].u_acc.acc}, 32'h7FF);
        chk("bin0_neg", {31'd0, dut.g_ch[0].u_acc.bin}, 32'd0);
        chk("bin1_neg", {31'd0, dut.g_ch[1].u_acc.bin}, 32'd0);
        set_psum_all(7'h01); tick(); psum_valid = 1'b0;
        chk("acc0_zero", {21'd0, dut.g_ch[0].u_acc.acc}, 32'd0);
        chk("bin0_zero", {31'd0, dut.g_ch[0].u_acc.bin}, 32'd1);
        chk("bin1_zero", {31'd0, dut.g_ch[1].u_acc.bin}, 32'd1);

        // saturation both ways
        set_bias_all(8'h7F);
        bias_wr = 1'b1; tick(); bias_wr = 1'b0;
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        set_psum_all(7'h3F); psum_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        psum_valid = 1'b0;
        chk("sat_pos", {21'd0, dut.g_ch[0].u_acc.acc}, 32'h3FF);
        set_bias_all(8'h80);
        bias_wr = 1'b1; tick(); bias_wr = 1'b0;
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        set_psum_all(7'h40); psum_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        psum_valid = 1'b0;
        chk("sat_neg", {21'd0, dut.g_ch[5].u_acc.acc}, 32'h400);

        // clear-plus-add, then same-cycle bias write uses the old bias
        set_bias_all(8'h0A);
        bias_wr = 1'b1; tick(); bias_wr = 1'b0;
        set_psum_all(7'h7D); acc_clr = 1'b1; psum_valid = 1'b1; tick();
        psum_valid = 1'b0; acc_clr = 1'b0;
        chk("clr_add", {21'd0, dut.g_ch[3].u_acc.acc}, 32'd7);
        set_bias_all(8'h14); bias_wr = 1'b1; acc_clr = 1'b1; tick();
        bias_wr = 1'b0;
        chk("clr_old_bias", {21'd0, dut.g_ch[3].u_acc.acc}, 32'd10);
        tick(); acc_clr = 1'b0;
        chk("clr_new_bias", {21'd0, dut.g_ch[3].u_acc.acc}, 32'd20);

        // pooling
        pool_en = 1'b1;
        write_row(8'h00); write_row(8'h00); write_row(8'h04);
        chk("pool_no_push", {29'd0, dut.row_cnt}, 32'd0);
        write_row(8'h00);
        chk("pool_push_cnt", {29'd0, dut.row_cnt}, 32'd1);
        chk("pool_row", {24'd0, dut.rows[0]}, 32'h04);
        write_row(8'h01); write_row(8'h02);
        pool_en = 1'b0;
        write_row(8'h80);
        chk("partial_cnt", {29'd0, dut.row_cnt}, 32'd2);
        chk("partial_row", {24'd0, dut.rows[1]}, 32'h80);
        write_row(8'h10);
        chk("partial_after", {24'd0, dut.rows[2]}, 32'h10);

        // drain and transpose
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < 7; r++) write_row(8'(1 << r));
        chk("fill_no_valid", {31'd0, out_valid}, 32'd0);
        write_row(8'h80);
        chk("drain_valid", {31'd0, out_valid}, 32'd1);
        chk("drain_beat0", out_data, 32'h08040201);
        tick();
        chk("drain_beat1", out_data, 32'h80402010);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("drain_done_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_done_data", out_data, 32'h80402010);
        chk("drain_done_cnt", {29'd0, dut.row_cnt}, 32'd0);

        // backpressure and overflow
        out_ready = 1'b0;
        load_bins(8'h0F);
        bin_wr = 1'b1;
        for (int r = 0; r < 8; r++) tick();
        chk("bp_beat0", out_data, 32'hFFFFFFFF);
        held = out_data;
        for (int i = 0; i < 5; i++) tick();
        bin_wr = 1'b0;
        chk("bp_stable", out_data, held);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        chk("bp_err", {31'd0, err_overflow}, 32'd1);
        chk("bp_row_cnt", {29'd0, dut.row_cnt}, 32'd0);
        out_ready = 1'b1; tick();
        chk("bp_beat1", out_data, 32'h00000000);
        tick();
        chk("bp_done_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_err_sticky", {31'd0, err_overflow}, 32'd1);

        // reset mid-drain
        out_ready = 1'b0;
        load_bins(8'h0F);
        bin_wr = 1'b1;
        for (int r = 0; r < 8; r++) tick();
        bin_wr = 1'b0;
        chk("mid_valid_pre", {31'd0, out_valid}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_err", {31'd0, err_overflow}, 32'd0);
        chk("mid_acc", {21'd0, dut.g_ch[0].u_acc.acc}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
